// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA frame controller.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    typedef logic [11:0] rgb12_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam rgb12_t RGB_WHITE = 12'hFFF;
    localparam rgb12_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern generator; blanks to black outside the visible area.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int HW        = 10
) (
    input  mode_e         mode,
    input  logic [HW-1:0] h,
    input  logic          v_sq,
    input  logic          de_i,
    output rgb12_t        rgb
);

    localparam int BAR_W = H_VISIBLE / 8;

    logic [2:0] bar_idx;

    always_comb begin
        bar_idx = 3'(h / HW'(BAR_W));
        rgb     = RGB_BLACK;
        if (de_i) begin
            case (mode)
                MODE_WHITE: rgb = RGB_WHITE;
                MODE_BARS:  rgb = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
                // 32-pixel squares: bit 5 of each coordinate selects the square parity
                MODE_CHECK: rgb = (h[5] ^ v_sq) ? RGB_WHITE : RGB_BLACK;
                default:    rgb = RGB_BLACK;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame controller: pixel counters, sync/blank decode, registered outputs
// and a host mode request that is applied only at the frame boundary.
module vga_frame_ctrl
    import vga_pkg::*;
#(
    parameter int H_VISIBLE       = DEF_H_VISIBLE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_VISIBLE       = DEF_V_VISIBLE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_mode,
    output logic        cfg_ready,
    output logic [11:0] rgb,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    mode_e         active_mode_q, active_mode_d;
    mode_e         pend_mode_q, pend_mode_d;
    logic          pending_q, pending_d;
    logic [7:0]    frame_count_q, frame_count_d;
    rgb12_t        rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          frame_start_q, frame_start_d;

    logic   h_wrap, frame_wrap;
    logic   de_i, hs_i, vs_i;
    rgb12_t pat_rgb;

    always_comb begin
        h_wrap     = (32'(h_q) == H_TOTAL - 1);
        frame_wrap = h_wrap && (32'(v_q) == V_TOTAL - 1);

        de_i = (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
        hs_i = (32'(h_q) >= H_VISIBLE + H_FP) && (32'(h_q) < H_VISIBLE + H_FP + H_SYNC);
        vs_i = (32'(v_q) >= V_VISIBLE + V_FP) && (32'(v_q) < V_VISIBLE + V_FP + V_SYNC);

        h_d = h_wrap ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_wrap) begin
            v_d = frame_wrap ? '0 : v_q + 1'b1;
        end

        active_mode_d = active_mode_q;
        pend_mode_d   = pend_mode_q;
        pending_d     = pending_q;
        if (frame_wrap && pending_q) begin
            active_mode_d = pend_mode_q;
            pending_d     = 1'b0;
        end
        // Acceptance is gated by the pre-apply pending flag, so a request taken on
        // the wrap cycle itself waits for the following frame boundary.
        if (cfg_valid && !pending_q) begin
            pend_mode_d = mode_e'(cfg_mode);
            pending_d   = 1'b1;
        end

        frame_count_d = frame_count_q;
        if (frame_wrap) begin
            frame_count_d = frame_count_q + 8'd1;
        end

        rgb_d         = pat_rgb;
        hs_d          = hs_i ^ SYNC_ACTIVE_LOW;
        vs_d          = vs_i ^ SYNC_ACTIVE_LOW;
        de_d          = de_i;
        frame_start_d = (h_q == '0) && (v_q == '0);
    end

    vga_pattern_gen #(
        .H_VISIBLE (H_VISIBLE),
        .HW        (HW)
    ) u_pattern_gen (
        .mode (active_mode_q),
        .h    (h_q),
        .v_sq (v_q[5]),
        .de_i (de_i),
        .rgb  (pat_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            active_mode_q <= MODE_WHITE;
            pend_mode_q   <= MODE_WHITE;
            pending_q     <= 1'b0;
            frame_count_q <= 8'd0;
            rgb_q         <= RGB_BLACK;
            hs_q          <= SYNC_ACTIVE_LOW;
            vs_q          <= SYNC_ACTIVE_LOW;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            active_mode_q <= active_mode_d;
            pend_mode_q   <= pend_mode_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cfg_ready   = !pending_q;
    assign rgb         = rgb_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl on a reduced 80x48 raster (64x40 visible).
module tb_vga_frame_ctrl;

    localparam int HV = 64, HFP = 4, HSY = 8, HBP = 4, HT = 80;
    localparam int VV = 40, VFP = 2, VSY = 3, VBP = 3, VT = 48;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic        cfg_ready;
    logic [11:0] rgb;
    logic        hs, vs, de, frame_start;
    logic [7:0]  frame_count;

    int n_cmp = 0;
    int n_err = 0;
    // Counter position held during the current cycle, and the position the outputs show.
    int ph = 0, pv = 0, oh = 0, ov = 0;

    logic [11:0] bars [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                              12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

    always #5 clk = ~clk;

    vga_frame_ctrl #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .SYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_mode    (cfg_mode),
        .cfg_ready   (cfg_ready),
        .rgb         (rgb),
        .hs          (hs),
        .vs          (vs),
        .de          (de),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        oh = ph;
        ov = pv;
        if (r) begin
            ph = 0;
            pv = 0;
        end else if (ph == HT - 1) begin
            ph = 0;
            pv = (pv == VT - 1) ? 0 : pv + 1;
        end else begin
            ph++;
        end
        #1;
    endtask

    task automatic goto_cnt(input int h, input int v, input string tag);
        int n = 0;
        while (!(ph == h && pv == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk(tag, 32'(ph == h && pv == v), 32'd1);
    endtask

    task automatic goto_out(input int h, input int v, input string tag);
        goto_cnt(h, v, tag);
        tick();
    endtask

    initial begin
        int hs_low = 0, vs_low = 0, de_hi = 0;
        int hs_pos = 0, vs_pos = 0, de_pos = 0, rgb_bad = 0;
        logic e_hs, e_vs, e_de;

        // Reset state
        tick();
        tick();
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // Two frames of default white output with timing checks
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (i == 0) begin
                chk("first_fs", 32'(frame_start), 32'd1);
                chk("first_de", 32'(de), 32'd1);
                chk("first_rgb", 32'(rgb), 32'hFFF);
            end
            e_hs = !(oh >= 68 && oh < 76);
            e_vs = !(ov >= 42 && ov < 45);
            e_de = (oh < 64) && (ov < 40);
            hs_low += (hs === 1'b0) ? 1 : 0;
            vs_low += (vs === 1'b0) ? 1 : 0;
            de_hi  += (de === 1'b1) ? 1 : 0;
            hs_pos += (hs !== e_hs) ? 1 : 0;
            vs_pos += (vs !== e_vs) ? 1 : 0;
            de_pos += (de !== e_de) ? 1 : 0;
            rgb_bad += (rgb !== (e_de ? 12'hFFF : 12'h000)) ? 1 : 0;
        end
        chk("hs_low_clocks", 32'(hs_low), 32'd768);
        chk("vs_low_clocks", 32'(vs_low), 32'd480);
        chk("de_high_clocks", 32'(de_hi), 32'd5120);
        chk("hs_position_errs", 32'(hs_pos), 32'd0);
        chk("vs_position_errs", 32'(vs_pos), 32'd0);
        chk("de_position_errs", 32'(de_pos), 32'd0);
        chk("white_rgb_errs", 32'(rgb_bad), 32'd0);
        chk("fc_after_2", 32'(frame_count), 32'd2);

        // Colour bars, requested at frame start, shown from the next frame
        chk("bars_ready_before", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        tick();
        cfg_valid = 1'b0;
        chk("bars_ready_drop", 32'(cfg_ready), 32'd0);
        goto_out(32, 0, "reach_w32");
        chk("bars_old_white", 32'(rgb), 32'hFFF);
        goto_cnt(0, 0, "reach_bars_frame");
        chk("bars_ready_back", 32'(cfg_ready), 32'd1);
        chk("fc_3", 32'(frame_count), 32'd3);
        for (int p = 0; p <= 64; p++) begin
            tick();
            if (p < 64) chk($sformatf("bar_px%0d", p), 32'(rgb), 32'(bars[p / 8]));
            else        chk("bar_px64_blank", 32'(rgb), 32'h000);
        end
        chk("bar_px64_de", 32'(de), 32'd0);

        // Checker requested mid-frame; bars persist to the end of this frame
        goto_cnt(20, 10, "reach_20_10");
        cfg_valid = 1'b1;
        cfg_mode  = 2'd2;
        tick();
        cfg_valid = 1'b0;
        chk("chk_ready_drop", 32'(cfg_ready), 32'd0);
        goto_out(63, 39, "reach_63_39");
        chk("chk_last_bar", 32'(rgb), 32'hFFF);
        goto_cnt(0, 0, "reach_chk_frame");
        chk("chk_ready_back", 32'(cfg_ready), 32'd1);
        chk("fc_4", 32'(frame_count), 32'd4);
        tick();
        chk("chk_0_0", 32'(rgb), 32'h000);
        chk("chk_0_0_fs", 32'(frame_start), 32'd1);
        goto_out(32, 0, "reach_32_0");
        chk("chk_32_0", 32'(rgb), 32'hFFF);
        goto_out(0, 32, "reach_0_32");
        chk("chk_0_32", 32'(rgb), 32'hFFF);
        goto_out(32, 32, "reach_32_32");
        chk("chk_32_32", 32'(rgb), 32'h000);

        // Held request while pending is ignored, then accepted after the apply
        goto_cnt(10, 35, "reach_10_35");
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        tick();
        chk("hold_accept_bars", 32'(cfg_ready), 32'd0);
        cfg_mode = 2'd3;
        tick();
        chk("hold_blocked", 32'(cfg_ready), 32'd0);
        goto_cnt(0, 0, "reach_hold_apply");
        chk("hold_ready_after_apply", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        chk("hold_black_accepted", 32'(cfg_ready), 32'd0);
        goto_out(32, 0, "reach_hold_32");
        chk("hold_bars_shown", 32'(rgb), 32'hF00);
        goto_cnt(0, 0, "reach_black_frame");
        chk("black_ready_back", 32'(cfg_ready), 32'd1);
        goto_out(32, 0, "reach_black_32");
        chk("black_32_0", 32'(rgb), 32'h000);
        chk("black_32_0_de", 32'(de), 32'd1);

        // Request accepted on the wrap cycle applies one frame later
        goto_cnt(HT - 1, VT - 1, "reach_wrap");
        chk("wrap_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd2;
        tick();
        cfg_valid = 1'b0;
        chk("wrap_still_pending", 32'(cfg_ready), 32'd0);
        goto_out(32, 0, "reach_wrap_32");
        chk("wrap_old_mode", 32'(rgb), 32'h000);
        goto_cnt(0, 0, "reach_wrap_apply");
        chk("wrap_ready_back", 32'(cfg_ready), 32'd1);
        goto_out(32, 0, "reach_wrap_apply_32");
        chk("wrap_new_mode", 32'(rgb), 32'hFFF);

        // Mid-frame reset with a pending request
        goto_cnt(10, 5, "reach_10_5");
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        tick();
        cfg_valid = 1'b0;
        chk("pre_rst_pending", 32'(cfg_ready), 32'd0);
        goto_cnt(30, 10, "reach_30_10");
        rst = 1'b1;
        tick();
        chk("mrst_rgb", 32'(rgb), 32'h000);
        chk("mrst_de", 32'(de), 32'd0);
        chk("mrst_fs", 32'(frame_start), 32'd0);
        chk("mrst_fc", 32'(frame_count), 32'd0);
        chk("mrst_hs", 32'(hs), 32'd1);
        chk("mrst_vs", 32'(vs), 32'd1);
        chk("mrst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        chk("post_rst_de", 32'(de), 32'd1);
        chk("post_rst_white", 32'(rgb), 32'hFFF);
        goto_cnt(0, 0, "reach_post_rst_frame");
        chk("post_rst_fc", 32'(frame_count), 32'd1);
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);
        goto_out(32, 0, "reach_post_rst_32");
        chk("pending_discarded", 32'(rgb), 32'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
